// File: rtl/uart_ram_loader.sv
// rtl/uart_ram_loader.sv - 8N1 serial receiver that loads a word stream into the program RAM.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte check.
module uart_ram_loader #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_hold,
    output logic                  ram_w_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_w_data,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]      CAPACITY  = 17'd1 << ADDR_WIDTH;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_CNT_HI  = 4'd1;
    localparam logic [3:0] S_CNT_LO  = 4'd2;
    localparam logic [3:0] S_DATA_HI = 4'd3;
    localparam logic [3:0] S_DATA_LO = 4'd4;
    localparam logic [3:0] S_WRITE   = 4'd5;
    localparam logic [3:0] S_CHECK   = 4'd6;
    localparam logic [3:0] S_DONE    = 4'd7;
    localparam logic [3:0] S_ERROR   = 4'd8;

`ifdef LOADER_CHECKSUM_EN
    localparam logic [3:0] S_FINISH = S_CHECK;
`else
    localparam logic [3:0] S_FINISH = S_DONE;
`endif

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [1:0]       rx_state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             byte_valid;
    logic             frame_err;

    logic [3:0]            state;
    logic                  error_r;
    logic [15:0]           count;
    logic [7:0]            hi_byte;
    logic [7:0]            lo_byte;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   words;
    logic [15:0]           count_next;
    logic [16:0]           words_after;
    logic                  loading;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            cks;
`endif

    // Receiver: start edge, mid-bit sampling, stop-bit validation.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= 3'd0;
            shift      <= 8'd0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        clk_cnt  <= '0;
                    end
                end
                RX_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt  <= '0;
                        bit_idx  <= 3'd0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign count_next  = {count[15:8], shift};
    assign words_after = 17'(words) + 17'd1;
    assign loading     = (state == S_CNT_HI) || (state == S_CNT_LO) || (state == S_DATA_HI) ||
                         (state == S_DATA_LO) || (state == S_CHECK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            error_r <= 1'b0;
            count   <= 16'd0;
            hi_byte <= 8'd0;
            lo_byte <= 8'd0;
            addr    <= '0;
            words   <= '0;
`ifdef LOADER_CHECKSUM_EN
            cks     <= 8'd0;
`endif
        end else if (frame_err && loading) begin
            state   <= S_ERROR;
            error_r <= 1'b1;
        end else begin
            case (state)
                S_IDLE, S_ERROR: begin
                    if (start) begin
                        state   <= S_CNT_HI;
                        error_r <= 1'b0;
                        addr    <= '0;
                        words   <= '0;
`ifdef LOADER_CHECKSUM_EN
                        cks     <= 8'd0;
`endif
                    end
                end
                S_CNT_HI: begin
                    if (byte_valid) begin
                        count[15:8] <= shift;
                        state       <= S_CNT_LO;
`ifdef LOADER_CHECKSUM_EN
                        cks         <= cks ^ shift;
`endif
                    end
                end
                S_CNT_LO: begin
                    if (byte_valid) begin
                        count[7:0] <= shift;
`ifdef LOADER_CHECKSUM_EN
                        cks        <= cks ^ shift;
`endif
                        if (count_next == 16'd0) begin
                            state <= S_FINISH;
                        end else if ({1'b0, count_next} > CAPACITY) begin
                            state   <= S_ERROR;
                            error_r <= 1'b1;
                        end else begin
                            state <= S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (byte_valid) begin
                        hi_byte <= shift;
                        state   <= S_DATA_LO;
`ifdef LOADER_CHECKSUM_EN
                        cks     <= cks ^ shift;
`endif
                    end
                end
                S_DATA_LO: begin
                    if (byte_valid) begin
                        lo_byte <= shift;
                        state   <= S_WRITE;
`ifdef LOADER_CHECKSUM_EN
                        cks     <= cks ^ shift;
`endif
                    end
                end
                S_WRITE: begin
                    // The final increment may wrap addr to 0; it is never used as an address.
                    addr  <= addr + 1'b1;
                    words <= words + 1'b1;
                    state <= (words_after == {1'b0, count}) ? S_FINISH : S_DATA_HI;
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (byte_valid) begin
                        if (shift == cks) begin
                            state <= S_DONE;
                        end else begin
                            state   <= S_ERROR;
                            error_r <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy         = loading || (state == S_WRITE);
    assign cpu_hold     = busy;
    assign done         = (state == S_DONE);
    assign error        = error_r;
    assign ram_w_en     = (state == S_WRITE);
    assign ram_addr     = addr;
    assign ram_w_data   = {hi_byte, lo_byte};
    assign words_loaded = words;

endmodule

// File: tb/tb_uart_ram_loader.sv
// tb/tb_uart_ram_loader.sv - randomized self-checking bench for uart_ram_loader against a stream-level model.
module tb_uart_ram_loader;

    localparam int CPB = 4;
    localparam int AW  = 12;
    localparam int DW  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx;
    logic          start;
    logic          busy;
    logic          done;
    logic          error;
    logic          cpu_hold;
    logic          ram_w_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_w_data;
    logic [AW:0]   words_loaded;

    always #5 clk = ~clk;

    uart_ram_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .rx(rx), .start(start),
        .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold),
        .ram_w_en(ram_w_en), .ram_addr(ram_addr), .ram_w_data(ram_w_data),
        .words_loaded(words_loaded)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Write/done observer
    logic [AW-1:0] wr_addr_q[$];
    logic [15:0]   wr_data_q[$];
    int            done_cnt  = 0;
    int            done_base = 0;
    int            wen_long  = 0;
    logic          prev_wen  = 1'b0;

    always @(negedge clk) begin
        if (ram_w_en) begin
            wr_addr_q.push_back(ram_addr);
            wr_data_q.push_back(ram_w_data);
        end
        if (ram_w_en && prev_wen) wen_long++;
        prev_wen = ram_w_en;
        if (done) done_cnt++;
    end

    // Reference: the words expected in RAM, in load order starting at address 0
    logic [15:0] exp_w[$];

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_base = done_cnt;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        @(negedge clk) rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
    endtask

    function automatic logic [7:0] stream_xor(input int cnt);
        logic [7:0] x;
        x = 8'(cnt >> 8) ^ 8'(cnt);
        foreach (exp_w[i]) x = x ^ exp_w[i][15:8] ^ exp_w[i][7:0];
        return x;
    endfunction

    task automatic send_body(input int cnt);
        send_byte(8'(cnt >> 8), 1'b1);
        send_byte(8'(cnt), 1'b1);
        foreach (exp_w[i]) begin
            send_byte(exp_w[i][15:8], 1'b1);
            send_byte(exp_w[i][7:0], 1'b1);
        end
    endtask

    task automatic send_stream(input int cnt);
        send_body(cnt);
`ifdef LOADER_CHECKSUM_EN
        send_byte(stream_xor(cnt), 1'b1);
`endif
    endtask

    task automatic wait_end(input string tag);
        bit timed_out;
        timed_out = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (done_cnt > done_base || error) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_timeout"}, 32'(timed_out), 32'd0);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwrites"}, wr_addr_q.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wr_addr_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[i]), i);
            check($sformatf("%s_data%0d", tag, i), 32'(wr_data_q[i]), 32'(exp_w[i]));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_cpu_hold"}, cpu_hold, 0);
        check({tag, "_wen"}, ram_w_en, 0);
        check({tag, "_addr"}, 32'(ram_addr), 0);
        check({tag, "_wdata"}, 32'(ram_w_data), 0);
        check({tag, "_words"}, 32'(words_loaded), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        rx    = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_idle_outputs("post_reset");

        // Nominal two-word load
        exp_w = '{16'h1234, 16'hABCD};
        clear_log();
        pulse_start();
        check("nom_busy", busy, 1);
        check("nom_hold", cpu_hold, 1);
        send_stream(2);
        wait_end("nom");
        repeat (2) @(negedge clk);
        check_writes("nom");
        check("nom_done", done_cnt - done_base, 1);
        check("nom_words", 32'(words_loaded), 2);
        check("nom_hold_after", cpu_hold, 0);
        check("nom_error", error, 0);

        // Zero-length load
        exp_w = {};
        clear_log();
        pulse_start();
        send_stream(0);
        wait_end("zero");
        repeat (2) @(negedge clk);
        check_writes("zero");
        check("zero_done", done_cnt - done_base, 1);
        check("zero_words", 32'(words_loaded), 0);
        check("zero_error", error, 0);

        // Framing error, then recovery
        exp_w = {};
        clear_log();
        pulse_start();
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h55, 1'b0);
        repeat (2) @(negedge clk);
        check("frm_error", error, 1);
        check("frm_busy", busy, 0);
        check_writes("frm");
        exp_w = '{16'h1234};
        clear_log();
        pulse_start();
        check("frm_err_cleared", error, 0);
        send_stream(1);
        wait_end("frm_rec");
        repeat (2) @(negedge clk);
        check_writes("frm_rec");
        check("frm_rec_error", error, 0);
        check("frm_rec_done", done_cnt - done_base, 1);

        // Glitch on rx while waiting for the count
        exp_w = '{16'hBEEF};
        clear_log();
        pulse_start();
        @(negedge clk) rx = 1'b0;
        @(negedge clk) rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_busy", busy, 1);
        check("glitch_error", error, 0);
        send_stream(1);
        wait_end("glitch");
        repeat (2) @(negedge clk);
        check_writes("glitch");
        check("glitch_done", done_cnt - done_base, 1);

        // Oversize count 4097
        exp_w = {};
        clear_log();
        pulse_start();
        send_byte(8'h10, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (2) @(negedge clk);
        check("over_error", error, 1);
        check("over_busy", busy, 0);
        check("over_done", done_cnt - done_base, 0);
        check_writes("over");

        // Reset between hi and lo byte of word index 3 of a 5-word load
        exp_w = {};
        for (int i = 0; i < 5; i++) exp_w.push_back(16'($urandom));
        clear_log();
        pulse_start();
        send_byte(8'h00, 1'b1);
        send_byte(8'h05, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send_byte(exp_w[i][15:8], 1'b1);
            send_byte(exp_w[i][7:0], 1'b1);
        end
        send_byte(exp_w[3][15:8], 1'b1);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("rst_mid");
        reset = 1'b0;
        send_byte(exp_w[3][7:0], 1'b1);
        send_byte(exp_w[4][15:8], 1'b1);
        send_byte(exp_w[4][7:0], 1'b1);
        repeat (4) @(negedge clk);
        void'(exp_w.pop_back());
        void'(exp_w.pop_back());
        check_writes("rst_mid");
        check("rst_mid_done", done_cnt - done_base, 0);

        // Randomized loads
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 6);
            exp_w = {};
            for (int i = 0; i < n; i++) exp_w.push_back(16'($urandom));
            clear_log();
            pulse_start();
            send_stream(n);
            wait_end($sformatf("rnd%0d", it));
            repeat (2) @(negedge clk);
            check_writes($sformatf("rnd%0d", it));
            check($sformatf("rnd%0d_words", it), 32'(words_loaded), n);
            check($sformatf("rnd%0d_done", it), done_cnt - done_base, 1);
            check($sformatf("rnd%0d_error", it), error, 0);
        end

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum byte: word still written, load ends in error
        exp_w = '{16'h1234};
        clear_log();
        pulse_start();
        send_body(1);
        send_byte(stream_xor(1) ^ 8'h01, 1'b1);
        repeat (2) @(negedge clk);
        check("cks_bad_error", error, 1);
        check("cks_bad_done", done_cnt - done_base, 0);
        check_writes("cks_bad");
`endif

        check("wen_single_cycle", wen_long, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
